inst_fetch: RTL and testbench

- Instruction-supply stage directly upstream of the processor core.
- Holds an 8-entry program store, loaded over a write port while idle.
- Sequences a program counter and presents one instruction at a time under a valid/ready handshake.
- Paces issue with a built-in tick divider, so the core steps at a human-visible rate on the board; also supports single-step for debug.

---
 rtl/inst_fetch.sv | 168 ++++++++++++++++
 tb/tb_inst_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch: instruction-supply stage for the processor core.
//
// Holds a small program store (written only while idle), walks a program
// counter over it and offers one instruction at a time on a valid/ready
// handshake. Issue is paced by a tick divider so the core steps at a visible
// rate; a single-step pulse fetches exactly one word while idle.
//
// Ports
//   clk, reset        rising-edge clock, async active-high reset
//   run               level, fetch continuously
//   step              pulse, fetch one word while idle
//   pc_clear          pulse, zero the pc (idle only)
//   load_en/addr/data program-store write port (idle only)
//   inst_ready        core accepts the presented word
//   instruction       presented word
//   address           pc of the presented word
//   inst_valid        instruction/address valid
//   busy              fetcher not idle
//   load_err          one-cycle pulse, load rejected because busy
//   fetch_count       completed handshakes, wraps at 2^32
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int TICK_DIV = 30000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              pc_clear,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] address,
    output logic              inst_valid,
    output logic              busy,
    output logic              load_err,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                valid_q, valid_d;
    logic                ss_q, ss_d;       // current word came from a single step
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                busy_q;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        ss_d    = ss_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        // Loads are only legal in IDLE; elsewhere flag them for one cycle.
        err_d   = load_en && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Strict priority; losing requests are dropped.
                if (load_en) begin
                    mem_we = 1'b1;
                end else if (pc_clear) begin
                    pc_d = '0;
                end else if (run) begin
                    state_d = S_FETCH;
                    tick_d  = '0;
                end else if (step) begin
                    inst_d  = mem_q[pc_q];
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    ss_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FETCH: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (tick_q == TICK_LAST) begin
                    inst_d  = mem_q[pc_q];
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_ISSUE: begin
                // run dropping here does not abort; the handshake finishes first.
                if (inst_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    ss_d    = 1'b0;
                    if (run && !ss_q) begin
                        state_d = S_FETCH;
                        tick_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            ss_q    <= 1'b0;
            tick_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            ss_q    <= ss_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Program store clears to NOP on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign instruction = inst_q;
    assign address     = addr_q;
    assign inst_valid  = valid_q;
    assign busy        = busy_q;
    assign load_err    = err_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, step = 1'b0, pc_clear = 1'b0, load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [2:0]  address;
    logic        inst_valid, busy, load_err;
    logic [31:0] fetch_count;

    inst_fetch #(.DEPTH(8), .ADDR_W(3), .DATA_W(32), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .pc_clear(pc_clear),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .inst_ready(inst_ready), .instruction(instruction), .address(address),
        .inst_valid(inst_valid), .busy(busy), .load_err(load_err),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: program contents, pc and handshake count.
    logic [31:0] m [8];
    int          mpc;
    logic [31:0] mcnt;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1'b1; load_addr = 3'(a); load_data = d;
        tick();
        load_en = 1'b0;
        m[a] = d;
        chk("load_err_idle", {63'd0, load_err}, 64'd0);
    endtask

    // Wait for inst_valid (bounded), then compare the presented word.
    // lat < 0 skips the latency comparison.
    task automatic expect_word(input string tag, input int lat);
        int n = 0;
        while (!inst_valid && n < 60) begin tick(); n++; end
        if (!inst_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
        if (lat >= 0) chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_addr"}, 64'(address), 64'(mpc));
        chk({tag, "_inst"}, 64'(instruction), 64'(m[mpc]));
        chk({tag, "_cnt"}, 64'(fetch_count), 64'(mcnt));
    endtask

    task automatic handshake();
        inst_ready = 1'b1;
        tick();
        mpc = (mpc + 1) % 8;
        mcnt = mcnt + 1;
        chk("hs_valid_low", {63'd0, inst_valid}, 64'd0);
        chk("hs_cnt", 64'(fetch_count), 64'(mcnt));
    endtask

    initial begin
        logic [31:0] hold_i;
        logic [2:0]  hold_a;
        for (int i = 0; i < 8; i++) m[i] = '0;
        mpc = 0; mcnt = 0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cnt", 64'(fetch_count), 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        reset = 1'b0;
        tick();

        // Program: fixed head, random tail
        load(0, 32'h10000005);
        load(1, 32'h10000003);
        load(2, 32'h20000000);
        for (int i = 3; i < 8; i++) load(i, $urandom);

        // Free run, ready tied high: nine words to cover the wrap
        run = 1'b1; inst_ready = 1'b1;
        tick();
        chk("run_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 9; k++) begin
            expect_word("run", TD);
            handshake();
        end
        chk("wrap_cnt9", 64'(fetch_count), 64'd9);

        // Word at address 1 passes, then backpressure at address 2
        expect_word("pre_bp", TD);
        handshake();
        inst_ready = 1'b0;
        expect_word("bp", TD);
        hold_i = instruction; hold_a = address;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_stable", {31'd0, inst_valid, hold_a, address, hold_i == instruction},
                {31'd0, 1'b1, hold_a, 3'd2, 1'b1});
        end
        handshake();

        // Load attempt while busy in FETCH: rejected, flagged one cycle
        load_en = 1'b1; load_addr = 3'd1; load_data = 32'hFFFFFFFF;
        tick();
        load_en = 1'b0;
        chk("lerr_pulse", {63'd0, load_err}, 64'd1);
        tick();
        chk("lerr_clear", {63'd0, load_err}, 64'd0);
        expect_word("after_lerr", -1);
        handshake();

        // Random backpressure until address 1 comes round again (mem[1] intact)
        for (int k = 0; k < 8; k++) begin
            int d;
            inst_ready = 1'b0;
            expect_word("rnd", -1);
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) tick();
            chk("rnd_hold", {63'd0, inst_valid}, 64'd1);
            handshake();
        end

        // pc_clear outside IDLE is ignored
        pc_clear = 1'b1; tick(); pc_clear = 1'b0;
        inst_ready = 1'b0;
        expect_word("pcclr_busy", -1);

        // run drops during ISSUE: handshake still completes, then IDLE
        run = 1'b0;
        tick();
        chk("issue_hold", {63'd0, inst_valid}, 64'd1);
        handshake();
        chk("stop_busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 6; c++) tick();
        chk("stop_novalid", {62'd0, inst_valid, busy}, 64'd0);

        // Single step from address 0
        pc_clear = 1'b1; tick(); pc_clear = 1'b0; mpc = 0;
        inst_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        expect_word("step0", 0);
        handshake();
        chk("step0_idle", {63'd0, busy}, 64'd0);
        tick(); tick();
        chk("step0_novalid", {63'd0, inst_valid}, 64'd0);
        step = 1'b1; tick(); step = 1'b0;
        expect_word("step1", 0);
        handshake();

        // Load beats step in the same cycle; step is dropped
        load_en = 1'b1; load_addr = 3'd2; load_data = 32'hCAFE0002; step = 1'b1;
        tick();
        load_en = 1'b0; step = 1'b0; m[2] = 32'hCAFE0002;
        chk("prio_nostep", {62'd0, inst_valid, busy}, 64'd0);
        inst_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        expect_word("prio_word", 0);

        // Async reset mid-ISSUE clears outputs before the next edge
        #2 reset = 1'b1;
        #1;
        chk("arst_outs", {instruction, 29'd0, inst_valid, busy, load_err},
            {32'd0, 32'd0});
        chk("arst_addr_cnt", {29'd0, address, fetch_count}, 64'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = '0;
        mpc = 0; mcnt = 0;
        tick();
        chk("arst_idle", {62'd0, inst_valid, busy}, 64'd0);
        step = 1'b1; tick(); step = 1'b0;
        expect_word("arst_nop", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
